rect_fill_ctrl: RTL and testbench
=================================

# rect_fill_ctrl

Sequencer for the rectangle-shape SRAM. On a start request it walks every pixel of a centred 2·half_width × 2·half_height rectangle in row-major order and writes a fill colour into the shape SRAM, one write per cycle. A display read port shares the same SRAM port and always has priority, stalling the fill. The block sits between the shape-configuration logic and the `sram` instance behind the rectangle drawer, and drives that instance's address, write-enable and data pins.

## Interface

Parameters:
- ADDR_WIDTH, 8, SRAM address width.
- DATA_WIDTH, 4, pixel colour width.
- DEPTH, 256, SRAM words; upper bound on W·H.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle fill request; honoured only in IDLE.
- i_half_width  in  11  rectangle half width; sampled with i_start.
- i_half_height  in  11  rectangle half height; sampled with i_start.
- i_color  in  DATA_WIDTH  fill colour; sampled with i_start.
- i_rd_req  in  1  display read request, priority over fill.
- i_rd_addr  in  ADDR_WIDTH  display read address.
- o_rd_valid  out  1  read data on SRAM o_data valid this cycle.
- o_mem_addr  out  ADDR_WIDTH  to SRAM i_addr.
- o_mem_write  out  1  to SRAM i_write.
- o_mem_data  out  DATA_WIDTH  to SRAM i_data.
- o_busy  out  1  high in FILL.
- o_done  out  1  one-cycle pulse on fill completion.
- o_err  out  1  one-cycle pulse on rejected start.

## Operation

- States: IDLE, FILL, DONE.
- IDLE + i_start: compute W = 2·i_half_width, H = 2·i_half_height, P = W·H in 24-bit unsigned arithmetic; latch W, H, P and colour.
  - P == 0 or P > DEPTH: pulse o_err next cycle and stay in IDLE.
  - Otherwise go to FILL with x = 0, y = 0.
- FILL, i_rd_req low: o_mem_write = 1, o_mem_addr = y·W + x truncated to ADDR_WIDTH, o_mem_data = latched colour. Then advance: x+1; when x == W−1, x wraps to 0 and y increments.
- FILL, i_rd_req high: o_mem_write = 0, o_mem_addr = i_rd_addr, and x, y hold. No write is lost or duplicated.
- After the write at (W−1, H−1), go to DONE. DONE asserts o_done for one cycle, then returns to IDLE.
- IDLE/DONE: o_mem_write = 0; o_mem_addr = i_rd_addr if i_rd_req is high, else 0; o_mem_data = latched colour.
- o_rd_valid is i_rd_req registered by one cycle, in every state.
- i_start outside IDLE is ignored; no o_err.
- o_mem_* are combinational from state, counters and i_rd_req. o_busy, o_done, o_err and o_rd_valid are registered.

## Timing

- Reset: state = IDLE, x = y = 0, latched W/H/P/colour = 0. All outputs are 0.
- rst mid-fill aborts at the next edge. No o_done; SRAM contents already written are left unchanged.
- With i_start at edge T and no reads: o_busy is high from T+1, the first write happens in cycle T+1, the last in cycle T+P, and o_done is high in cycle T+P+1.
- Each cycle with i_rd_req high during FILL delays o_done by exactly one cycle.
- Read latency: address in cycle n, o_rd_valid and SRAM o_data valid in cycle n+1.
- o_err is high in cycle T+1 for a rejected start.

## Configuration

- RECT_FILL_BORDER_EN defined: only pixels with x == 0, x == W−1, y == 0 or y == H−1 receive the latched colour. Interior pixels are written with 0. The write count and timing are unchanged.
- Undefined: every pixel receives the latched colour.

## Test plan

- hw=2, hh=1, colour 0xA, no reads: 8 writes to addresses 0..7, all data 0xA; o_busy high in cycles 1–8 after start, o_done in cycle 9.
- Same fill with i_rd_req high for 3 cycles mid-fill (rd_addr 0x55): o_mem_addr = 0x55 and o_mem_write = 0 during those cycles; o_rd_valid high on the following 3 cycles; addresses 0..7 still each written once; o_done delayed 3 cycles.
- hw=0, hh=5, and separately hw=16, hh=8 (P = 512 > 256): o_err pulse, no writes, o_busy stays low.
- i_start pulsed again during FILL with different sizes: ignored; the original 8-write sequence completes unchanged.
- rst asserted after the 4th write: next cycle all outputs 0 and state IDLE; no o_done; a new start then fills from address 0.
- With RECT_FILL_BORDER_EN, hw=2, hh=2 (4×4), colour 0xF: addresses 5, 6, 9, 10 receive 0; the other 12 receive 0xF.

Source files
------------

// File: rtl/rect_fill_ctrl.sv
// Rectangle fill sequencer: walks a centred 2*hw x 2*hh rectangle and writes a colour
// into the shape SRAM, yielding the port to display reads. Option: RECT_FILL_BORDER_EN.
module rect_fill_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 4,
   parameter int DEPTH      = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [10:0]           i_half_width,
   input  logic [10:0]           i_half_height,
   input  logic [DATA_WIDTH-1:0] i_color,
   input  logic                  i_rd_req,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic                  o_rd_valid,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic                  o_mem_write,
   output logic [DATA_WIDTH-1:0] o_mem_data,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] FILL = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]            state;
   logic [11:0]           w, h, x, y;
   logic [23:0]           p;
   logic [DATA_WIDTH-1:0] color;

   logic [23:0]           w_in, h_in, p_in, lin;
   logic                  bad, step, last, x_wrap;
   logic [DATA_WIDTH-1:0] pixel;

   assign w_in   = {12'd0, i_half_width, 1'b0};
   assign h_in   = {12'd0, i_half_height, 1'b0};
   assign p_in   = w_in * h_in;
   assign bad    = (p_in == 24'd0) || (p_in > 24'(DEPTH));
   assign lin    = ({12'd0, y} * {12'd0, w}) + {12'd0, x};
   assign step   = (state == FILL) && !i_rd_req;
   assign x_wrap = (x == w - 12'd1);
   // Linear index reaching P-1 only happens on the final row; both terms agree.
   assign last   = (lin == p - 24'd1) && (y == h - 12'd1);

`ifdef RECT_FILL_BORDER_EN
   always_comb begin
      pixel = '0;
      if (x == 12'd0 || x_wrap || y == 12'd0 || y == h - 12'd1)
         pixel = color;
   end
`else
   assign pixel = color;
`endif

   // Display reads own the SRAM port whenever requested.
   always_comb begin
      o_mem_write = 1'b0;
      o_mem_addr  = '0;
      o_mem_data  = color;
      if (i_rd_req) begin
         o_mem_addr = i_rd_addr;
      end else if (state == FILL) begin
         o_mem_write = 1'b1;
         o_mem_addr  = lin[ADDR_WIDTH-1:0];
         o_mem_data  = pixel;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         x          <= '0;
         y          <= '0;
         w          <= '0;
         h          <= '0;
         p          <= '0;
         color      <= '0;
         o_rd_valid <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_err      <= 1'b0;
      end else begin
         o_rd_valid <= i_rd_req;
         o_err      <= (state == IDLE) && i_start && bad;
         o_done     <= step && last;
         o_busy     <= ((state == IDLE) && i_start && !bad) ||
                       ((state == FILL) && !(step && last));
         case (state)
            IDLE: begin
               if (i_start) begin
                  w     <= w_in[11:0];
                  h     <= h_in[11:0];
                  p     <= p_in;
                  color <= i_color;
                  if (!bad) begin
                     state <= FILL;
                     x     <= '0;
                     y     <= '0;
                  end
               end
            end
            FILL: begin
               if (step) begin
                  if (last) begin
                     state <= DONE;
                  end else if (x_wrap) begin
                     x <= '0;
                     y <= y + 12'd1;
                  end else begin
                     x <= x + 12'd1;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rect_fill_ctrl.sv
// Directed bench for rect_fill_ctrl; border expectations follow RECT_FILL_BORDER_EN.
module tb_rect_fill_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_start;
   logic [10:0] i_half_width, i_half_height;
   logic [3:0] i_color;
   logic       i_rd_req;
   logic [7:0] i_rd_addr;
   logic       o_rd_valid, o_mem_write, o_busy, o_done, o_err;
   logic [7:0] o_mem_addr;
   logic [3:0] o_mem_data;

   int checks = 0;
   int errors = 0;

   logic [7:0] wr_addr_q[$];
   logic [3:0] wr_data_q[$];
   int done_cnt = 0;
   int err_cnt  = 0;

   rect_fill_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(4), .DEPTH(256)) dut (
      .clk(clk), .rst(rst), .i_start(i_start),
      .i_half_width(i_half_width), .i_half_height(i_half_height),
      .i_color(i_color), .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr),
      .o_rd_valid(o_rd_valid), .o_mem_addr(o_mem_addr), .o_mem_write(o_mem_write),
      .o_mem_data(o_mem_data), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
   );

   always #5 clk = ~clk;

   // Record SRAM writes and pulses mid-cycle.
   always @(negedge clk) begin
      if (o_mem_write) begin
         wr_addr_q.push_back(o_mem_addr);
         wr_data_q.push_back(o_mem_data);
      end
      if (o_done) done_cnt++;
      if (o_err) err_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_fill(input int hw, input int hh, input logic [3:0] col);
      i_start       = 1'b1;
      i_half_width  = 11'(hw);
      i_half_height = 11'(hh);
      i_color       = col;
      tick();
      i_start = 1'b0;
   endtask

   function automatic logic [3:0] exp_pixel(input int x, input int y, input int wv,
                                            input int hv, input logic [3:0] col);
`ifdef RECT_FILL_BORDER_EN
      if (x == 0 || x == wv - 1 || y == 0 || y == hv - 1) return col;
      return 4'h0;
`else
      if (wv + hv + x + y < 0) return 4'h0;
      return col;
`endif
   endfunction

   task automatic check_log(input string tag, input int base, input int n, input int wv,
                            input int hv, input logic [3:0] col);
      chk({tag, "_count"}, 32'(wr_addr_q.size() - base), 32'(n));
      for (int i = 0; i < n && base + i < wr_addr_q.size(); i++) begin
         chk({tag, "_addr"}, 32'(wr_addr_q[base+i]), 32'(i));
         chk({tag, "_data"}, 32'(wr_data_q[base+i]), 32'(exp_pixel(i % wv, i / wv, wv, hv, col)));
      end
   endtask

   initial begin
      int base;
      int dbase;
      int ebase;
      rst = 1'b1; i_start = 1'b0; i_half_width = '0; i_half_height = '0;
      i_color = '0; i_rd_req = 1'b0; i_rd_addr = '0;
      tick(); tick();

      // reset state
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_done", 32'(o_done), 0);
      chk("rst_err", 32'(o_err), 0);
      chk("rst_rd_valid", 32'(o_rd_valid), 0);
      chk("rst_write", 32'(o_mem_write), 0);
      chk("rst_addr", 32'(o_mem_addr), 0);
      chk("rst_data", 32'(o_mem_data), 0);
      rst = 1'b0;
      tick();

      // basic 4x2 fill
      base = wr_addr_q.size(); dbase = done_cnt;
      start_fill(2, 1, 4'hA);
      for (int c = 1; c <= 8; c++) begin
         chk("t1_busy", 32'(o_busy), 1);
         chk("t1_write", 32'(o_mem_write), 1);
         chk("t1_addr", 32'(o_mem_addr), 32'(c - 1));
         chk("t1_data", 32'(o_mem_data), 32'hA);
         chk("t1_done_early", 32'(o_done), 0);
         tick();
      end
      chk("t1_done", 32'(o_done), 1);
      chk("t1_busy_end", 32'(o_busy), 0);
      chk("t1_write_end", 32'(o_mem_write), 0);
      tick();
      chk("t1_done_pulse", 32'(o_done), 0);
      check_log("t1", base, 8, 4, 2, 4'hA);
      chk("t1_done_cnt", 32'(done_cnt - dbase), 1);

      // display reads stall the fill
      base = wr_addr_q.size(); dbase = done_cnt;
      start_fill(2, 1, 4'hA);
      for (int c = 0; c < 3; c++) begin
         chk("t2_addr_pre", 32'(o_mem_addr), 32'(c));
         tick();
      end
      i_rd_req = 1'b1; i_rd_addr = 8'h55;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t2_rd_addr", 32'(o_mem_addr), 32'h55);
         chk("t2_rd_write", 32'(o_mem_write), 0);
         chk("t2_rd_busy", 32'(o_busy), 1);
         if (k > 0) chk("t2_rd_valid", 32'(o_rd_valid), 1);
         tick();
      end
      i_rd_req = 1'b0; i_rd_addr = 8'h00;
      #1;
      chk("t2_rd_valid_last", 32'(o_rd_valid), 1);
      chk("t2_resume_addr", 32'(o_mem_addr), 3);
      chk("t2_resume_write", 32'(o_mem_write), 1);
      tick();
      for (int a = 4; a <= 7; a++) begin
         if (a == 4) chk("t2_rd_valid_off", 32'(o_rd_valid), 0);
         chk("t2_addr_post", 32'(o_mem_addr), 32'(a));
         chk("t2_done_early", 32'(o_done), 0);
         tick();
      end
      chk("t2_done", 32'(o_done), 1);
      tick();
      check_log("t2", base, 8, 4, 2, 4'hA);
      chk("t2_done_cnt", 32'(done_cnt - dbase), 1);

      // rejected starts: zero area, and areas above DEPTH
      base = wr_addr_q.size(); ebase = err_cnt;
      start_fill(0, 5, 4'h3);
      chk("t3a_err", 32'(o_err), 1);
      chk("t3a_busy", 32'(o_busy), 0);
      chk("t3a_write", 32'(o_mem_write), 0);
      tick();
      chk("t3a_err_pulse", 32'(o_err), 0);
      chk("t3a_busy2", 32'(o_busy), 0);
      start_fill(16, 8, 4'h3);
      chk("t3b_err", 32'(o_err), 1);
      chk("t3b_busy", 32'(o_busy), 0);
      tick();
      chk("t3b_err_pulse", 32'(o_err), 0);
      start_fill(13, 5, 4'h3);
      chk("t3c_err", 32'(o_err), 1);
      tick();
      chk("t3_no_writes", 32'(wr_addr_q.size() - base), 0);
      chk("t3_err_cnt", 32'(err_cnt - ebase), 3);

      // start during FILL is ignored
      base = wr_addr_q.size(); dbase = done_cnt; ebase = err_cnt;
      start_fill(2, 1, 4'hA);
      tick(); tick();
      i_start = 1'b1; i_half_width = 11'd3; i_half_height = 11'd3; i_color = 4'h5;
      tick();
      i_start = 1'b0;
      repeat (5) tick();
      chk("t4_done", 32'(o_done), 1);
      tick();
      check_log("t4", base, 8, 4, 2, 4'hA);
      chk("t4_no_err", 32'(err_cnt - ebase), 0);
      chk("t4_done_cnt", 32'(done_cnt - dbase), 1);

      // reset mid-fill after the fourth write
      base = wr_addr_q.size(); dbase = done_cnt;
      start_fill(2, 1, 4'hA);
      tick(); tick(); tick();
      chk("t5_fourth_addr", 32'(o_mem_addr), 3);
      rst = 1'b1;
      tick();
      chk("t5_busy", 32'(o_busy), 0);
      chk("t5_done", 32'(o_done), 0);
      chk("t5_err", 32'(o_err), 0);
      chk("t5_rd_valid", 32'(o_rd_valid), 0);
      chk("t5_write", 32'(o_mem_write), 0);
      chk("t5_addr", 32'(o_mem_addr), 0);
      chk("t5_data", 32'(o_mem_data), 0);
      rst = 1'b0;
      repeat (10) tick();
      chk("t5_writes", 32'(wr_addr_q.size() - base), 4);
      chk("t5_no_done", 32'(done_cnt - dbase), 0);
      base = wr_addr_q.size();
      start_fill(2, 1, 4'h6);
      chk("t5_restart_addr", 32'(o_mem_addr), 0);
      chk("t5_restart_write", 32'(o_mem_write), 1);
      repeat (8) tick();
      chk("t5_restart_done", 32'(o_done), 1);
      tick();
      check_log("t5r", base, 8, 4, 2, 4'h6);

      // 4x4 fill (interior pixels depend on border option)
      base = wr_addr_q.size();
      start_fill(2, 2, 4'hF);
      repeat (16) tick();
      chk("t6_done", 32'(o_done), 1);
      tick();
      check_log("t6", base, 16, 4, 4, 4'hF);

      // exactly DEPTH pixels is accepted
      base = wr_addr_q.size();
      start_fill(8, 8, 4'h9);
      chk("t7_busy", 32'(o_busy), 1);
      chk("t7_no_err", 32'(o_err), 0);
      repeat (256) tick();
      chk("t7_done", 32'(o_done), 1);
      tick();
      check_log("t7", base, 256, 16, 16, 4'h9);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
